ex_muldiv_unit: RTL

- Parametrised iterative multiply/divide unit for the EX stage of the 5-stage pipeline.
- Computes unsigned and signed multiply and divide, one bit per cycle, into a HI/LO result pair.
- `busy` feeds the pipeline stall network: the EX instruction and all younger stages freeze while it is high.
- `flush` from branch/jump resolution aborts an in-flight operation.

---
 rtl/ex_muldiv_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Brief    : Iterative shift-add multiply / restoring divide for the EX stage.
//            Optional early-out path guarded by MULDIV_EARLY_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int c_CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a_orig;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_nxt_hi;
    logic [WIDTH-1:0]   w_nxt_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;
    logic               w_early;
    logic               w_early_dbz;
    logic [WIDTH-1:0]   w_early_hi;
    logic [WIDTH-1:0]   w_early_lo;

    assign w_abs_a = (op[0] && a[WIDTH-1]) ? -a : a;
    assign w_abs_b = (op[0] && b[WIDTH-1]) ? -b : b;

    // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
    // divide shifts the dividend out of acc_lo into the remainder and the quotient in.
    always_comb begin
        w_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
        w_shift  = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_diff   = w_shift - {1'b0, r_opnd};
        w_nxt_hi = w_sum[WIDTH:1];
        w_nxt_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};
        if (r_is_div) begin
            if (!w_diff[WIDTH]) begin
                w_nxt_hi = w_diff[WIDTH-1:0];
                w_nxt_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_nxt_hi = w_shift[WIDTH-1:0];
                w_nxt_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        w_prod     = {w_nxt_hi, w_nxt_lo};
        w_prod_fix = r_neg_res ? -w_prod : w_prod;
        w_fin_hi   = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fin_lo   = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            if (r_b_zero) begin
                w_fin_hi = r_a_orig;
                w_fin_lo = '1;
            end else begin
                w_fin_hi = r_neg_rem ? -w_nxt_hi : w_nxt_hi;
                w_fin_lo = r_neg_res ? -w_nxt_lo : w_nxt_lo;
            end
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    always_comb begin
        w_early     = op[1] ? ((b == '0) || (w_abs_a < w_abs_b)) : ((a == '0) || (b == '0));
        w_early_dbz = op[1] && (b == '0);
        w_early_hi  = op[1] ? a : '0;
        w_early_lo  = w_early_dbz ? '1 : '0;
    end
`else
    assign w_early     = 1'b0;
    assign w_early_dbz = 1'b0;
    assign w_early_hi  = '0;
    assign w_early_lo  = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_opnd    <= '0;
            r_a_orig  <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_dbz   <= 1'b0;
                    if (start) begin
                        r_is_div  <= op[1];
                        r_neg_res <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_rem <= op[0] & a[WIDTH-1];
                        r_b_zero  <= (b == '0);
                        r_a_orig  <= a;
                        r_opnd    <= op[1] ? w_abs_b : w_abs_a;
                        r_acc_lo  <= op[1] ? w_abs_a : w_abs_b;
                        r_acc_hi  <= '0;
                        if (w_early) begin
                            r_state <= S_DONE;
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                            r_dbz   <= w_early_dbz;
                            r_hi    <= w_early_hi;
                            r_lo    <= w_early_lo;
                        end else begin
                            r_state <= S_CALC;
                            r_cnt   <= c_CNT_W'(WIDTH);
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_acc_hi <= w_nxt_hi;
                    r_acc_lo <= w_nxt_lo;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_dbz   <= r_is_div & r_b_zero;
                        r_hi    <= w_fin_hi;
                        r_lo    <= w_fin_lo;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire
